output_port_scheduler: RTL and testbench

Per-output-port scheduler for the credit-based router. It shares one output port among the five input ports (N, E, W, S, L) and arbitrates round-robin at packet granularity: a winner keeps the port until its tail flit has been transferred. It tracks downstream buffer credits and gates every flit transfer on credit availability. One instance sits on each output port, downstream of the input-side arbiters and upstream of the output crossbar select.

---
 rtl/output_port_scheduler.sv | 145 ++++++++++++++
 tb/tb_output_port_scheduler.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/output_port_scheduler.sv
`default_nettype none
// ============================================================================
// output_port_scheduler
//   Credit-gated, packet-granular round-robin scheduler for one router port.
// Revision: 1.0
// ============================================================================
module output_port_scheduler #(
    parameter int CREDIT_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_n,
    input  logic             req_e,
    input  logic             req_w,
    input  logic             req_s,
    input  logic             req_l,
    input  logic             valid_n,
    input  logic             valid_e,
    input  logic             valid_w,
    input  logic             valid_s,
    input  logic             valid_l,
    input  logic             tail_n,
    input  logic             tail_e,
    input  logic             tail_w,
    input  logic             tail_s,
    input  logic             tail_l,
    input  logic             credit_in,
    output logic             grant_n,
    output logic             grant_e,
    output logic             grant_w,
    output logic             grant_s,
    output logic             grant_l,
    output logic             valid_out,
    output logic [CNT_W-1:0] credit_cnt,
    output logic             credit_err
);

    localparam logic [CNT_W-1:0] C_CMAX = CNT_W'(CREDIT_MAX);
    localparam logic [CNT_W-1:0] C_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [4:0]       owner_q, owner_d;
    logic [4:0]       rr_q, rr_d;
    logic [CNT_W-1:0] credit_q, credit_d;
    logic             err_q, err_d;

    // Bit order everywhere: {L, S, W, E, N}
    logic [4:0] req_v, valid_v, tail_v, grant_v, win;
    logic [2:0] rr_idx;
    logic [3:0] idx;
    logic       found, xfer, tail_xfer;

    assign req_v   = {req_l, req_s, req_w, req_e, req_n};
    assign valid_v = {valid_l, valid_s, valid_w, valid_e, valid_n};
    assign tail_v  = {tail_l, tail_s, tail_w, tail_e, tail_n};

    assign grant_v   = (state_q == S_LOCKED && credit_q != '0) ? (owner_q & valid_v) : 5'b0;
    assign xfer      = |grant_v;
    assign tail_xfer = |(grant_v & tail_v);

    // First requester at or after the round-robin pointer, wrapping L->N
    always_comb begin
        rr_idx = 3'd0;
        for (int i = 0; i < 5; i++) begin
            if (rr_q[i]) rr_idx = 3'(i);
        end
        win   = 5'b0;
        found = 1'b0;
        idx   = 4'd0;
        for (int k = 0; k < 5; k++) begin
            idx = {1'b0, rr_idx} + 4'(k);
            if (idx >= 4'd5) idx = idx - 4'd5;
            if (!found && req_v[idx[2:0]]) begin
                win[idx[2:0]] = 1'b1;
                found         = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d = S_LOCKED;
                    owner_d = win;
                    rr_d    = {win[3:0], win[4]};
                end
            end
            S_LOCKED: begin
                if (tail_xfer) begin
                    state_d = S_IDLE;
                    owner_d = 5'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        credit_d = credit_q;
        err_d    = err_q;
        if (credit_in && !xfer) begin
            if (credit_q == C_CMAX) err_d = 1'b1;
            else                    credit_d = credit_q + C_ONE;
        end else if (!credit_in && xfer) begin
            credit_d = credit_q - C_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            owner_q  <= 5'b0;
            rr_q     <= 5'b00001;
            credit_q <= C_CMAX;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_q     <= rr_d;
            credit_q <= credit_d;
            err_q    <= err_d;
        end
    end

    assign grant_n    = grant_v[0];
    assign grant_e    = grant_v[1];
    assign grant_w    = grant_v[2];
    assign grant_s    = grant_v[3];
    assign grant_l    = grant_v[4];
    assign valid_out  = xfer;
    assign credit_cnt = credit_q;
    assign credit_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_output_port_scheduler.sv
`default_nettype none
// ============================================================================
// tb_output_port_scheduler
//   Directed vector table plus hand-written multi-cycle sequences.
// Revision: 1.0
// ============================================================================
module tb_output_port_scheduler;

    localparam logic [4:0] N = 5'b00001;
    localparam logic [4:0] E = 5'b00010;
    localparam logic [4:0] W = 5'b00100;
    localparam logic [4:0] S = 5'b01000;
    localparam logic [4:0] L = 5'b10000;
    localparam logic [4:0] Z = 5'b00000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] req = '0, valid = '0, tail = '0;
    logic       credit_in = 1'b0;
    logic [4:0] grant;
    logic       valid_out, credit_err;
    logic [2:0] credit_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    output_port_scheduler #(.CREDIT_MAX(4), .CNT_W(3)) dut (
        .clk(clk), .reset(reset),
        .req_n(req[0]), .req_e(req[1]), .req_w(req[2]), .req_s(req[3]), .req_l(req[4]),
        .valid_n(valid[0]), .valid_e(valid[1]), .valid_w(valid[2]), .valid_s(valid[3]), .valid_l(valid[4]),
        .tail_n(tail[0]), .tail_e(tail[1]), .tail_w(tail[2]), .tail_s(tail[3]), .tail_l(tail[4]),
        .credit_in(credit_in),
        .grant_n(grant[0]), .grant_e(grant[1]), .grant_w(grant[2]), .grant_s(grant[3]), .grant_l(grant[4]),
        .valid_out(valid_out), .credit_cnt(credit_cnt), .credit_err(credit_err)
    );

    typedef struct {
        logic       rst;
        logic [4:0] req;
        logic [4:0] valid;
        logic [4:0] tail;
        logic       cin;
        logic [4:0] g;
        logic [2:0] cnt;
        logic       err;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string name, input logic [4:0] eg, input logic [2:0] ecnt, input logic eerr);
        chk({name, ".grant"}, 32'(grant), 32'(eg));
        chk({name, ".valid_out"}, 32'(valid_out), 32'(|eg));
        chk({name, ".credit_cnt"}, 32'(credit_cnt), 32'(ecnt));
        chk({name, ".credit_err"}, 32'(credit_err), 32'(eerr));
    endtask

    // Called at posedge+1; leaves at the following posedge+1
    task automatic step(input string name, input logic [4:0] r, input logic [4:0] v, input logic [4:0] t,
                        input logic ci, input logic [4:0] eg, input logic [2:0] ecnt, input logic eerr);
        req = r; valid = v; tail = t; credit_in = ci;
        #2;
        chk_out(name, eg, ecnt, eerr);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        req = '0; valid = '0; tail = '0; credit_in = 1'b0;
        reset = 1'b0;
        #2;
        chk_out("in_reset", Z, 3'd4, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        // Three-flit packet on E from reset
        tbl[0]  = '{1'b1, E, E, Z, 1'b0, Z, 3'd4, 1'b0};
        tbl[1]  = '{1'b0, E, E, Z, 1'b0, E, 3'd4, 1'b0};
        tbl[2]  = '{1'b0, E, E, Z, 1'b0, E, 3'd3, 1'b0};
        tbl[3]  = '{1'b0, E, E, E, 1'b0, E, 3'd2, 1'b0};
        tbl[4]  = '{1'b0, Z, Z, Z, 1'b0, Z, 3'd1, 1'b0};
        tbl[5]  = '{1'b0, Z, E, Z, 1'b0, Z, 3'd1, 1'b0};
        // Round robin N, E, L, N with single-flit packets; credit_in every cycle
        tbl[6]  = '{1'b1, N|E|L, N|E|L, N|E|L, 1'b1, Z, 3'd4, 1'b0};
        tbl[7]  = '{1'b0, N|E|L, N|E|L, N|E|L, 1'b1, N, 3'd4, 1'b1};
        tbl[8]  = '{1'b0, N|E|L, N|E|L, N|E|L, 1'b1, Z, 3'd4, 1'b1};
        tbl[9]  = '{1'b0, N|E|L, N|E|L, N|E|L, 1'b1, E, 3'd4, 1'b1};
        tbl[10] = '{1'b0, N|E|L, N|E|L, N|E|L, 1'b1, Z, 3'd4, 1'b1};
        tbl[11] = '{1'b0, N|E|L, N|E|L, N|E|L, 1'b1, L, 3'd4, 1'b1};
        tbl[12] = '{1'b0, N|E|L, N|E|L, N|E|L, 1'b1, Z, 3'd4, 1'b1};
        tbl[13] = '{1'b0, N|E|L, N|E|L, N|E|L, 1'b1, N, 3'd4, 1'b1};

        for (int i = 0; i < 14; i++) begin
            if (tbl[i].rst) do_reset();
            step($sformatf("tbl%0d", i), tbl[i].req, tbl[i].valid, tbl[i].tail, tbl[i].cin,
                 tbl[i].g, tbl[i].cnt, tbl[i].err);
        end

        // Credit stall: 6-flit packet on W, no credits returned
        do_reset();
        step("stall_arb", W, W, Z, 1'b0, Z, 3'd4, 1'b0);
        step("stall_f1",  W, W, Z, 1'b0, W, 3'd4, 1'b0);
        step("stall_f2",  W, W, Z, 1'b0, W, 3'd3, 1'b0);
        step("stall_f3",  W, W, Z, 1'b0, W, 3'd2, 1'b0);
        step("stall_f4",  W, W, Z, 1'b0, W, 3'd1, 1'b0);
        step("stall_0",   W, W, Z, 1'b0, Z, 3'd0, 1'b0);
        step("stall_cin", W, W, Z, 1'b1, Z, 3'd0, 1'b0);
        step("stall_f5",  W, W, Z, 1'b0, W, 3'd1, 1'b0);
        step("stall_1",   W, W, Z, 1'b0, Z, 3'd0, 1'b0);

        // Lock hold on S, with a simultaneous credit/transfer at count 2
        do_reset();
        step("lock_arb",  S, S, Z, 1'b0, Z, 3'd4, 1'b0);
        step("lock_f1",   S, S, Z, 1'b0, S, 3'd4, 1'b0);
        step("lock_f2",   S, S, Z, 1'b0, S, 3'd3, 1'b0);
        step("lock_hold", N, N, Z, 1'b0, Z, 3'd2, 1'b0);
        step("lock_tail", N, N|S, S, 1'b1, S, 3'd2, 1'b0);
        step("lock_bub",  N, N, Z, 1'b0, Z, 3'd2, 1'b0);
        step("lock_n",    N, N, Z, 1'b0, N, 3'd2, 1'b0);

        // Overflow, then reset in the middle of a packet
        do_reset();
        step("ovf_pulse", Z, Z, Z, 1'b1, Z, 3'd4, 1'b0);
        step("ovf_arb",   E, E, Z, 1'b0, Z, 3'd4, 1'b1);
        step("ovf_f1",    E, E, Z, 1'b0, E, 3'd4, 1'b1);
        req = E; valid = E; tail = Z; credit_in = 1'b0;
        #2;
        chk_out("mid_f2", E, 3'd3, 1'b1);
        reset = 1'b0;
        #1;
        chk_out("mid_rst", Z, 3'd4, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        step("post_rst", Z, E, Z, 1'b0, Z, 3'd4, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
